// File: rtl/compress_scheduler.sv
// compress_scheduler: feeds sparse counters row by row to SENSE_COL column
// compress units, captures the per-column sums they return after the last
// row of each slice, and drains them as a serial (slice, column, value) stream.
// Optional build macro: ZERO_SKIP_EN -- when defined, zero column sums are
// skipped during drain (one column per cycle) instead of being emitted.
module compress_scheduler #(
    parameter int NUM_COUNTER = 10,
    parameter int NUM_SLICE   = 2,
    parameter int SENSE_COL   = 3,
    parameter int DATA_W      = 32
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          In_Valid,
    input  logic [DATA_W-1:0]             In_Data,
    output logic                          In_Ready,
    output logic                          Col_Valid,
    output logic [DATA_W-1:0]             Col_Data,
    output logic [7:0]                    Col_Row,
    output logic                          Col_Last,
    input  logic                          Col_Sum_Valid,
    input  logic [SENSE_COL*DATA_W-1:0]   Col_Sum,
    output logic                          Out_Valid,
    output logic [DATA_W-1:0]             Out_Data,
    output logic [7:0]                    Out_Col,
    output logic [7:0]                    Out_Slice,
    input  logic                          Out_Ready,
    output logic                          Busy,
    output logic                          Done
);

    localparam int COL_W = (SENSE_COL > 1) ? $clog2(SENSE_COL) : 1;
    localparam logic [7:0]       ROW_LAST   = 8'(NUM_COUNTER - 1);
    localparam logic [7:0]       SLICE_LAST = 8'(NUM_SLICE - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(SENSE_COL - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FEED     = 3'd1,
        S_WAIT_SUM = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         row_q, row_d;
    logic [7:0]         slice_q, slice_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [DATA_W-1:0]  bank_q [SENSE_COL];
    logic [DATA_W-1:0]  bank_d [SENSE_COL];
    logic               col_valid_q, col_valid_d;
    logic [DATA_W-1:0]  col_data_q, col_data_d;
    logic [7:0]         col_row_q, col_row_d;
    logic               col_last_q, col_last_d;

    logic               accept_s;
    logic               out_valid_s;
    logic               advance_s;
    logic               skip_s;

    // Handshake and drain qualifiers decoded from the registered state.
    assign accept_s    = (state_q == S_FEED) && In_Valid;
`ifdef ZERO_SKIP_EN
    logic col_zero_s;
    assign col_zero_s  = (bank_q[col_q] == {DATA_W{1'b0}});
    assign out_valid_s = (state_q == S_DRAIN) && !col_zero_s;
    assign skip_s      = (state_q == S_DRAIN) && col_zero_s;
`else
    assign out_valid_s = (state_q == S_DRAIN);
    assign skip_s      = 1'b0;
`endif
    assign advance_s   = (out_valid_s && Out_Ready) || skip_s;

    // Next-state, counter, beat and sum-bank logic for the run sequencer.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        slice_d     = slice_q;
        col_d       = col_q;
        bank_d      = bank_q;
        col_valid_d = 1'b0;
        col_data_d  = col_data_q;
        col_row_d   = col_row_q;
        col_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_FEED;
                    row_d   = 8'd0;
                    slice_d = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FEED: begin
                if (accept_s) begin
                    col_valid_d = 1'b1;
                    col_data_d  = In_Data;
                    col_row_d   = row_q;
                    col_last_d  = (row_q == ROW_LAST);
                    if (row_q == ROW_LAST) begin
                        row_d   = 8'd0;
                        state_d = S_WAIT_SUM;
                    end else begin
                        row_d   = row_q + 8'd1;
                    end
                end else begin
                    row_d = row_q;
                end
            end
            S_WAIT_SUM: begin
                if (Col_Sum_Valid) begin
                    for (int c = 0; c < SENSE_COL; c++) begin
                        bank_d[c] = Col_Sum[c*DATA_W +: DATA_W];
                    end
                    col_d   = {COL_W{1'b0}};
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT_SUM;
                end
            end
            S_DRAIN: begin
                if (advance_s) begin
                    if (col_q == COL_LAST) begin
                        col_d = {COL_W{1'b0}};
                        if (slice_q == SLICE_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            slice_d = slice_q + 8'd1;
                            state_d = S_FEED;
                        end
                    end else begin
                        col_d = col_q + {{(COL_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    col_d = col_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, broadcast beat and sum bank registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            row_q       <= 8'd0;
            slice_q     <= 8'd0;
            col_q       <= {COL_W{1'b0}};
            col_valid_q <= 1'b0;
            col_data_q  <= {DATA_W{1'b0}};
            col_row_q   <= 8'd0;
            col_last_q  <= 1'b0;
            for (int c = 0; c < SENSE_COL; c++) begin
                bank_q[c] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            slice_q     <= slice_d;
            col_q       <= col_d;
            col_valid_q <= col_valid_d;
            col_data_q  <= col_data_d;
            col_row_q   <= col_row_d;
            col_last_q  <= col_last_d;
            for (int c = 0; c < SENSE_COL; c++) begin
                bank_q[c] <= bank_d[c];
            end
        end
    end

    assign In_Ready  = (state_q == S_FEED);
    assign Col_Valid = col_valid_q;
    assign Col_Data  = col_data_q;
    assign Col_Row   = col_row_q;
    assign Col_Last  = col_last_q;
    assign Out_Valid = out_valid_s;
    assign Out_Data  = bank_q[col_q];
    assign Out_Col   = 8'(col_q);
    assign Out_Slice = slice_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);

endmodule
